// File: rtl/cache_arbiter.sv
// Arbitrates I-cache and D-cache line requests onto one burst memory port.
// Lines move as BEATS beats; the arbiter alternates grants when both ports request.
module cache_arbiter #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_read,
    input  logic [31:0]       icache_address,
    output logic [LINE_W-1:0] icache_rdata,
    output logic              icache_resp,
    input  logic              dcache_read,
    input  logic              dcache_write,
    input  logic [31:0]       dcache_address,
    input  logic [LINE_W-1:0] dcache_wdata,
    output logic [LINE_W-1:0] dcache_rdata,
    output logic              dcache_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [31:0]       pmem_address,
    output logic [BEAT_W-1:0] pmem_burst_wdata,
    input  logic [BEAT_W-1:0] pmem_burst_rdata,
    input  logic              pmem_resp
);

    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        I_READ,
        D_READ,
        D_WRITE,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     beat_q, beat_d;
    logic              last_d_q, last_d_d;
    logic              gnt_d_q, gnt_d_d;
    logic [31:5]       addr_q, addr_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [LINE_W-1:0] irdata_q, irdata_d;
    logic [LINE_W-1:0] drdata_q, drdata_d;
    logic [LINE_W-1:0] fill_line;
    logic              i_req, d_req, last_beat;
    logic              unused_addr_lsbs;

    assign unused_addr_lsbs = ^{icache_address[4:0], dcache_address[4:0]};

    assign i_req     = icache_read;
    assign d_req     = dcache_read | dcache_write;
    assign last_beat = (beat_q == CW'(BEATS - 1));

    always_comb begin
        fill_line = line_q;
        fill_line[beat_q*BEAT_W +: BEAT_W] = pmem_burst_rdata;
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        last_d_d    = last_d_q;
        gnt_d_d     = gnt_d_q;
        addr_d      = addr_q;
        line_d      = line_q;
        irdata_d    = irdata_q;
        drdata_d    = drdata_q;
        pmem_read   = 1'b0;
        pmem_write  = 1'b0;
        icache_resp = 1'b0;
        dcache_resp = 1'b0;
        unique case (state_q)
            IDLE: begin
                // D wins a conflict unless it was the one served last
                if (d_req && (!i_req || !last_d_q)) begin
                    gnt_d_d = 1'b1;
                    addr_d  = dcache_address[31:5];
                    beat_d  = '0;
                    if (dcache_write) begin
                        line_d  = dcache_wdata;
                        state_d = D_WRITE;
                    end else begin
                        state_d = D_READ;
                    end
                end else if (i_req) begin
                    gnt_d_d = 1'b0;
                    addr_d  = icache_address[31:5];
                    beat_d  = '0;
                    state_d = I_READ;
                end
            end
            I_READ, D_READ: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    line_d = fill_line;
                    beat_d = beat_q + CW'(1);
                    if (last_beat) begin
                        beat_d  = '0;
                        state_d = DONE;
                        if (state_q == I_READ) irdata_d = fill_line;
                        else                   drdata_d = fill_line;
                    end
                end
            end
            D_WRITE: begin
                pmem_write = 1'b1;
                if (pmem_resp) begin
                    beat_d = beat_q + CW'(1);
                    if (last_beat) begin
                        beat_d  = '0;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                icache_resp = !gnt_d_q;
                dcache_resp = gnt_d_q;
                last_d_d    = gnt_d_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            last_d_q <= 1'b0;
            gnt_d_q  <= 1'b0;
            addr_q   <= '0;
            line_q   <= '0;
            irdata_q <= '0;
            drdata_q <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            last_d_q <= last_d_d;
            gnt_d_q  <= gnt_d_d;
            addr_q   <= addr_d;
            line_q   <= line_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
        end
    end

    assign pmem_address     = {addr_q, 5'b0};
    assign pmem_burst_wdata = line_q[beat_q*BEAT_W +: BEAT_W];
    assign icache_rdata     = irdata_q;
    assign dcache_rdata     = drdata_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter with an inline burst-memory responder.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_cache_arbiter;

    localparam int LW = 256;
    localparam int BW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          icache_read;
    logic [31:0]   icache_address;
    logic [LW-1:0] icache_rdata;
    logic          icache_resp;
    logic          dcache_read;
    logic          dcache_write;
    logic [31:0]   dcache_address;
    logic [LW-1:0] dcache_wdata;
    logic [LW-1:0] dcache_rdata;
    logic          dcache_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [31:0]   pmem_address;
    logic [BW-1:0] pmem_burst_wdata;
    logic [BW-1:0] pmem_burst_rdata;
    logic          pmem_resp;

    cache_arbiter #(.LINE_W(LW), .BEAT_W(BW)) dut (
        .clk              (clk),
        .rst              (rst),
        .icache_read      (icache_read),
        .icache_address   (icache_address),
        .icache_rdata     (icache_rdata),
        .icache_resp      (icache_resp),
        .dcache_read      (dcache_read),
        .dcache_write     (dcache_write),
        .dcache_address   (dcache_address),
        .dcache_wdata     (dcache_wdata),
        .dcache_rdata     (dcache_rdata),
        .dcache_resp      (dcache_resp),
        .pmem_read        (pmem_read),
        .pmem_write       (pmem_write),
        .pmem_address     (pmem_address),
        .pmem_burst_wdata (pmem_burst_wdata),
        .pmem_burst_rdata (pmem_burst_rdata),
        .pmem_resp        (pmem_resp)
    );

    always #5 clk = ~clk;

    int            nvec = 0;
    int            nerr = 0;
    logic [BW-1:0] rbeat [4];
    logic [BW-1:0] wcap  [4];
    logic [31:0]   acap;
    logic          saw_rd, saw_wr;
    logic [LW-1:0] line, ld2, li2, exp_i;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [LW-1:0] obs,
                        input logic [LW-1:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Waits for a burst, serves four beats, returns on the DONE cycle
    task automatic xfer(input int gap, input int drop_k, input bit scramble);
        int n = 0;
        saw_rd = 1'b0;
        saw_wr = 1'b0;
        while (!(pmem_read || pmem_write) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk1("burst_start", pmem_read || pmem_write, 1'b1);
        if (scramble) begin
            icache_address = 32'hffff_ffff;
            dcache_address = 32'hdead_beef;
            dcache_wdata   = {LW{1'b1}};
        end
        for (int k = 0; k < 4; k++) begin
            repeat (gap) @(negedge clk);
            pmem_resp        = 1'b1;
            pmem_burst_rdata = rbeat[k];
            wcap[k]          = pmem_burst_wdata;
            acap             = pmem_address;
            saw_rd           = saw_rd | pmem_read;
            saw_wr           = saw_wr | pmem_write;
            if (k == drop_k) begin
                icache_read  = 1'b0;
                dcache_read  = 1'b0;
                dcache_write = 1'b0;
            end
            @(negedge clk);
            pmem_resp = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b0;
        icache_read = 0; icache_address = 0;
        dcache_read = 0; dcache_write = 0;
        dcache_address = 0; dcache_wdata = '0;
        pmem_burst_rdata = '0; pmem_resp = 0;
        repeat (2) @(negedge clk);
        chk1("rst_pmem_read", pmem_read, 1'b0);
        chk1("rst_pmem_write", pmem_write, 1'b0);
        chk1("rst_iresp", icache_resp, 1'b0);
        chk1("rst_dresp", dcache_resp, 1'b0);
        chkw("rst_irdata", icache_rdata, '0);
        chkw("rst_drdata", dcache_rdata, '0);
        rst = 1'b1;
        @(negedge clk);
        chk1("idle_no_req", pmem_read | pmem_write, 1'b0);

        // Conflict from reset: D, I, D, I
        icache_read = 1; dcache_read = 1;
        icache_address = 32'h0000_0100;
        dcache_address = 32'h0000_0200;
        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < 4; k++)
                rbeat[k] = 64'hc000_0000_0000_0000 | 64'(t * 4 + k);
            line = {rbeat[3], rbeat[2], rbeat[1], rbeat[0]};
            xfer(0, -1, 1'b0);
            if (t == 3) begin
                icache_read = 0; dcache_read = 0;
            end
            chk1("conf_dresp", dcache_resp, (t % 2) == 0);
            chk1("conf_iresp", icache_resp, (t % 2) == 1);
            chkw("conf_addr", LW'(acap),
                 LW'((t % 2 == 0) ? 32'h200 : 32'h100));
            chkw("conf_line", (t % 2 == 0) ? dcache_rdata : icache_rdata,
                 line);
            if (t == 2) ld2 = line;
            if (t == 3) li2 = line;
        end
        @(negedge clk);
        chk1("conf_end_resp", icache_resp | dcache_resp, 1'b0);

        // Plain I-cache fill
        rbeat[0] = {16{4'h1}}; rbeat[1] = {16{4'h2}};
        rbeat[2] = {16{4'h3}}; rbeat[3] = {16{4'h4}};
        exp_i = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        icache_address = 32'h0000_1234;
        icache_read = 1;
        xfer(0, -1, 1'b0);
        chkw("ifill_addr", LW'(acap), LW'(32'h0000_1220));
        chk1("ifill_iresp", icache_resp, 1'b1);
        chk1("ifill_dresp", dcache_resp, 1'b0);
        chk1("ifill_rd_off", pmem_read, 1'b0);
        chkw("ifill_line", icache_rdata, exp_i);
        chkw("ifill_dline", dcache_rdata, ld2);
        icache_read = 0;
        @(negedge clk);
        chk1("ifill_single", icache_resp, 1'b0);

        // Spurious pmem_resp in IDLE
        pmem_resp = 1; pmem_burst_rdata = '1;
        @(negedge clk);
        pmem_resp = 0;
        chk1("spur_rd", pmem_read | pmem_write, 1'b0);
        chk1("spur_resp", icache_resp | dcache_resp, 1'b0);
        @(negedge clk);
        chkw("spur_iline", icache_rdata, exp_i);
        chk1("spur_idle", pmem_read | pmem_write, 1'b0);

        // Writeback with read+write both high, gapped beats
        dcache_wdata = {{16{4'hd}}, {16{4'hc}}, {16{4'hb}}, {16{4'ha}}};
        dcache_address = 32'h8000_0040;
        dcache_write = 1; dcache_read = 1;
        for (int k = 0; k < 4; k++) rbeat[k] = '0;
        xfer(2, -1, 1'b1);
        chkw("wb_beat0", LW'(wcap[0]), LW'({16{4'ha}}));
        chkw("wb_beat1", LW'(wcap[1]), LW'({16{4'hb}}));
        chkw("wb_beat2", LW'(wcap[2]), LW'({16{4'hc}}));
        chkw("wb_beat3", LW'(wcap[3]), LW'({16{4'hd}}));
        chk1("wb_is_write", saw_wr, 1'b1);
        chk1("wb_no_read", saw_rd, 1'b0);
        chkw("wb_addr", LW'(acap), LW'(32'h8000_0040));
        chk1("wb_dresp", dcache_resp, 1'b1);
        chk1("wb_iresp", icache_resp, 1'b0);
        chkw("wb_dline", dcache_rdata, ld2);
        dcache_write = 0; dcache_read = 0;
        @(negedge clk);
        chk1("wb_single", dcache_resp, 1'b0);

        // Requester drops after beat 1
        rbeat[0] = {16{4'h5}}; rbeat[1] = {16{4'h6}};
        rbeat[2] = {16{4'h7}}; rbeat[3] = {16{4'h8}};
        dcache_address = 32'h0000_3000;
        dcache_read = 1;
        xfer(1, 1, 1'b0);
        chk1("drop_dresp", dcache_resp, 1'b1);
        chkw("drop_line", dcache_rdata,
             {{16{4'h8}}, {16{4'h7}}, {16{4'h6}}, {16{4'h5}}});
        @(negedge clk);
        chk1("drop_no_retry", pmem_read | dcache_resp, 1'b0);

        // Reset in the middle of a D read
        dcache_address = 32'h0000_4000;
        dcache_read = 1;
        begin
            int n = 0;
            while (!pmem_read && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        chk1("mid_start", pmem_read, 1'b1);
        for (int k = 0; k < 2; k++) begin
            pmem_resp = 1; pmem_burst_rdata = {16{4'h9}};
            @(negedge clk);
        end
        pmem_resp = 0;
        rst = 1'b0;
        #1;
        chk1("mid_rd_off", pmem_read, 1'b0);
        chk1("mid_dresp", dcache_resp, 1'b0);
        chkw("mid_dline", dcache_rdata, '0);
        chkw("mid_iline", icache_rdata, '0);
        dcache_read = 0;
        repeat (2) begin
            @(negedge clk);
            chk1("mid_no_resp", dcache_resp | icache_resp, 1'b0);
        end
        rst = 1'b1;
        @(negedge clk);

        rbeat[0] = {16{4'he}}; rbeat[1] = {16{4'hf}};
        rbeat[2] = {16{4'h1}}; rbeat[3] = {16{4'h2}};
        icache_address = 32'h0000_5008;
        icache_read = 1;
        xfer(0, -1, 1'b0);
        icache_read = 0;
        chk1("post_iresp", icache_resp, 1'b1);
        chkw("post_addr", LW'(acap), LW'(32'h0000_5000));
        chkw("post_line", icache_rdata,
             {{16{4'h2}}, {16{4'h1}}, {16{4'hf}}, {16{4'he}}});
        @(negedge clk);
        chk1("post_single", icache_resp, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
